embed_spi_loader: RTL and testbench
===================================

Name: embed_spi_loader

Overview:
- Serial responder for the embed-mode program-load link: the external host drives spi_clk and spi_mosi, and receives spi_miso.
- Deserialises framed write and read requests: start bit, 24-bit address, write-enable bit, and 16-bit data, all LSB first.
- Executes each request as a single Wishbone-style master cycle on the internal memory bus.
- Signals completion to the host on spi_miso, and returns read data on spi_miso.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on spi_clk and spi_mosi (minimum 2).
- BUS_TIMEOUT, 255, number of i_clk cycles a bus cycle may wait for ack/err before it is aborted.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous active-high reset
- i_enable  input  1  embed-mode enable; when low, the FSM is held in IDLE
- i_spi_clk  input  1  host serial clock (asynchronous)
- i_spi_mosi  input  1  host serial data
- o_spi_miso  output  1  status / read-data line back to the host
- o_wb_cyc  output  1  bus cycle
- o_wb_stb  output  1  bus strobe
- o_wb_we  output  1  bus write enable
- o_wb_adr  output  24  bus address
- o_wb_dat  output  16  bus write data
- i_wb_dat  input  16  bus read data
- i_wb_ack  input  1  bus acknowledge
- i_wb_err  input  1  bus error
- o_err  output  1  sticky error flag (bus error or timeout); cleared by reset only
- o_busy  output  1  high in every state except IDLE

Behaviour:
- Reset values:
  - o_spi_miso=1.
  - o_wb_cyc, o_wb_stb, o_wb_we = 0.
  - o_wb_adr=0, o_wb_dat=0.
  - o_err=0, o_busy=0.
  - State = IDLE; shift registers and counters = 0.
- Input synchronisation and edge detection:
  - i_spi_clk and i_spi_mosi each pass through SYNC_STAGES flip-flops.
  - An "edge" is a synchronised 0->1 transition of spi_clk.
  - The synchronised mosi value is sampled in the same cycle the edge is detected.
  - The host holds each clock level for at least 2 i_clk cycles.
- FSM (all transitions except those in BUS are taken on an edge):
  - IDLE: if mosi=0 and i_enable=1, go to ADDR with bit counter=0.
  - ADDR: shift mosi into adr[cnt]; after 24 bits go to WE.
  - WE: latch we=mosi. If we=1, go to DATA; otherwise go to BUS.
  - DATA: shift mosi into dat[cnt]; after 16 bits go to BUS.
  - BUS:
    - On entry, in the cycle after the last bit, assert cyc=stb=1 with we, adr and dat driven.
    - Hold until i_wb_ack, i_wb_err, or the timeout counter reaches BUS_TIMEOUT.
    - On ack with we=0, capture i_wb_dat into rdata.
    - On err or timeout, set o_err=1.
    - In every case, deassert cyc/stb in the next cycle and go to DONE.
  - DONE: o_spi_miso=0. On an edge, go to RDOUT if the request was a read and the bus cycle ended with ack; otherwise go to IDLE.
  - RDOUT:
    - o_spi_miso = rdata[cnt].
    - Each edge increments cnt.
    - After the 16th edge, go to IDLE.
- o_spi_miso is 1 in IDLE, ADDR, WE, DATA and BUS. The host clocks while miso=1, then performs one more clock after seeing 0.
- A read ending in err or timeout returns no data bits: DONE goes directly to IDLE.
- Edges that arrive while in BUS are ignored and do not shift any register.
- i_enable falling mid-frame:
  - An in-flight bus cycle completes normally; the FSM then returns to IDLE without waiting for DONE's edge.
  - In any other state, the FSM returns to IDLE in the next cycle.
- i_rst mid-operation: all state, bus outputs and o_err return to reset values immediately (asynchronous).
- Latency: the bus cycle starts 1 i_clk after the edge that delivers the final bit. miso goes low 1 cycle after the ack.
- The timeout counter is 8 bits wide when BUS_TIMEOUT=255. It clears on entry to BUS.

Test Plan:
- Write: frame with addr=0x800000, we=1, data=0x000E -> one bus cycle with adr=0x800000, we=1, dat=0x000E. After ack, miso=0; after one more host clock, miso=1 and the FSM is in IDLE; o_err=0.
- Read: frame with addr=0x800011, we=0; bus returns i_wb_dat=0x3888 -> miso=0, then 16 bits 0,0,0,1,0,0,0,1,0,0,0,1,1,1,0,0 (LSB first) sampled before each rising clock; then IDLE.
- Bus error: write to 0x000010 with i_wb_err pulsed -> o_err=1 (sticky across the next frame); DONE reached; no retry.
- Timeout: read with ack never asserted -> cyc drops after 255 cycles, o_err=1, no data bits returned, FSM in IDLE after one clock.
- Abort: assert i_rst after 10 address bits -> all outputs at reset values. A subsequent full write frame of addr 0x800001, data 0x0008 completes correctly.
- Back-to-back: 64 consecutive writes to 0x800000–0x80003F -> 64 bus cycles in order with matching adr/dat, and no edge is lost.

Source files
------------

// File: rtl/embed_spi_loader.sv
// rtl/embed_spi_loader.sv - serial program-load responder that turns host frames into single bus cycles
module embed_spi_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_spi_clk,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [23:0] o_wb_adr,
    output logic [15:0] o_wb_dat,
    input  logic [15:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_err,
    output logic        o_busy
);
    localparam int TW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WE, S_DATA, S_BUS, S_DONE, S_RDOUT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    state_t                 state_q;
    logic [4:0]             cnt_q;
    logic [TW-1:0]          tmo_q;
    logic [23:0]            adr_q;
    logic [15:0]            dat_q;
    logic [15:0]            rdata_q;
    logic                   we_q;
    logic                   cyc_q;
    logic                   rd_ok_q;
    logic                   miso_q;
    logic                   err_q;

    logic       spi_edge;
    logic       mosi_s;
    logic [3:0] rd_idx_next;

    assign spi_edge    = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign rd_idx_next = cnt_q[3:0] + 4'd1;

    // Bring the asynchronous host lines into the i_clk domain and remember the last clock level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    // Frame FSM: shifts the request in, runs the bus cycle, then reports status / read data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            miso_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_q <= 1'b1;
                    if (spi_edge && !mosi_s && i_enable) begin
                        state_q <= S_ADDR;
                        cnt_q   <= '0;
                    end
                end
                S_ADDR: begin
                    if (!i_enable) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (spi_edge) begin
                        adr_q[cnt_q] <= mosi_s;
                        if (cnt_q == 5'd23) begin
                            cnt_q   <= '0;
                            state_q <= S_WE;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                S_WE: begin
                    if (!i_enable) begin
                        state_q <= S_IDLE;
                    end else if (spi_edge) begin
                        we_q  <= mosi_s;
                        cnt_q <= '0;
                        if (mosi_s) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_BUS;
                            cyc_q   <= 1'b1;
                            tmo_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (!i_enable) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (spi_edge) begin
                        dat_q[cnt_q[3:0]] <= mosi_s;
                        if (cnt_q == 5'd15) begin
                            cnt_q   <= '0;
                            state_q <= S_BUS;
                            cyc_q   <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                S_BUS: begin
                    // Host edges are ignored here; the cycle always runs to ack, err or timeout
                    if (i_wb_ack || i_wb_err || (tmo_q == TW'(BUS_TIMEOUT))) begin
                        cyc_q <= 1'b0;
                        if (i_wb_ack) begin
                            if (!we_q) begin
                                rdata_q <= i_wb_dat;
                            end
                            rd_ok_q <= !we_q;
                        end else begin
                            err_q   <= 1'b1;
                            rd_ok_q <= 1'b0;
                        end
                        if (i_enable) begin
                            state_q <= S_DONE;
                            miso_q  <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!i_enable) begin
                        state_q <= S_IDLE;
                        miso_q  <= 1'b1;
                    end else if (spi_edge) begin
                        if (rd_ok_q) begin
                            state_q <= S_RDOUT;
                            cnt_q   <= '0;
                            miso_q  <= rdata_q[0];
                        end else begin
                            state_q <= S_IDLE;
                            miso_q  <= 1'b1;
                        end
                    end
                end
                S_RDOUT: begin
                    if (!i_enable || (spi_edge && cnt_q == 5'd15)) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        miso_q  <= 1'b1;
                    end else if (spi_edge) begin
                        cnt_q  <= cnt_q + 5'd1;
                        miso_q <= rdata_q[rd_idx_next];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    miso_q  <= 1'b1;
                end
            endcase
        end
    end

    assign o_spi_miso = miso_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = cyc_q;
    assign o_wb_we    = we_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_err      = err_q;
    assign o_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_embed_spi_loader.sv
// tb/tb_embed_spi_loader.sv - randomized self-checking bench for embed_spi_loader
module tb_embed_spi_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b1;
    logic        miso;
    logic        cyc, stb, we;
    logic [23:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdat_bus = '0;
    logic        ack = 1'b0;
    logic        berr = 1'b0;
    logic        err_o, busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic err_exp = 1'b0;

    embed_spi_loader #(.SYNC_STAGES(2), .BUS_TIMEOUT(255)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_spi_clk(sclk), .i_spi_mosi(mosi), .o_spi_miso(miso),
        .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
        .o_wb_adr(adr), .o_wb_dat(wdat), .i_wb_dat(rdat_bus),
        .i_wb_ack(ack), .i_wb_err(berr), .o_err(err_o), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        tick(3);
        sclk = 1'b1;
        tick(3);
        sclk = 1'b0;
    endtask

    task automatic spi_sample(output logic b);
        mosi = 1'b1;
        tick(3);
        b = miso;
        sclk = 1'b1;
        tick(3);
        sclk = 1'b0;
    endtask

    // resp: 0 = ack, 1 = bus error, 2 = no response (timeout)
    task automatic do_txn(input logic [23:0] a, input logic w, input logic [15:0] d,
                          input int resp, input logic [15:0] rd);
        int   n;
        logic b;
        spi_bit(1'b0);
        for (int i = 0; i < 24; i++) spi_bit(a[i]);
        spi_bit(w);
        if (w) for (int i = 0; i < 16; i++) spi_bit(d[i]);
        n = 0;
        while (!cyc && n < 20) begin tick(1); n++; end
        check("cyc_start", 32'(cyc), 32'd1);
        check("stb", 32'(stb), 32'd1);
        check("adr", 32'(adr), 32'(a));
        check("we", 32'(we), 32'(w));
        if (w) check("dat", 32'(wdat), 32'(d));
        check("miso_bus", 32'(miso), 32'd1);
        check("busy_bus", 32'(busy), 32'd1);
        if (resp == 2) begin
            n = 0;
            while (cyc && n < 400) begin tick(1); n++; end
            check("tmo_len", 32'(n >= 250 && n <= 260), 32'd1);
        end else begin
            tick($urandom_range(0, 4));
            rdat_bus = rd;
            if (resp == 0) ack = 1'b1; else berr = 1'b1;
            tick(1);
            ack = 1'b0;
            berr = 1'b0;
            rdat_bus = 16'($urandom);
            check("cyc_end", 32'(cyc), 32'd0);
        end
        if (resp != 0) err_exp = 1'b1;
        check("miso_done", 32'(miso), 32'd0);
        check("err", 32'(err_o), 32'(err_exp));
        spi_bit(1'b1);
        if (resp == 0 && !w) begin
            for (int i = 0; i < 16; i++) begin
                spi_sample(b);
                check("rbit", 32'(b), 32'(rd[i]));
            end
        end
        tick(3);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_miso", 32'(miso), 32'd1);
        check("idle_cyc", 32'(cyc), 32'd0);
    endtask

    initial begin
        logic [23:0] ra;
        logic [15:0] rd, rr;
        logic        rw;
        int          rsp;
        tick(3);
        check("rst_miso", 32'(miso), 32'd1);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_adr", 32'(adr), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(3);

        do_txn(24'h800000, 1'b1, 16'h000E, 0, 16'h0000);
        do_txn(24'h800011, 1'b0, 16'h0000, 0, 16'h3888);
        do_txn(24'h000010, 1'b1, 16'h1234, 1, 16'h0000);
        do_txn(24'h000020, 1'b1, 16'h5678, 0, 16'h0000);
        do_txn(24'h800022, 1'b0, 16'h0000, 2, 16'h0000);

        // enable drop mid-frame, then low-enable start bits are ignored
        spi_bit(1'b0);
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        en = 1'b0;
        tick(2);
        check("en_busy", 32'(busy), 32'd0);
        check("en_miso", 32'(miso), 32'd1);
        spi_bit(1'b0);
        check("en_hold", 32'(busy), 32'd0);
        mosi = 1'b1;
        en = 1'b1;
        tick(3);

        // reset after 10 address bits
        spi_bit(1'b0);
        for (int i = 0; i < 10; i++) spi_bit(1'b1);
        rst = 1'b1;
        tick(1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_adr", 32'(adr), 32'd0);
        check("abort_err", 32'(err_o), 32'd0);
        check("abort_miso", 32'(miso), 32'd1);
        rst = 1'b0;
        err_exp = 1'b0;
        tick(3);
        do_txn(24'h800001, 1'b1, 16'h0008, 0, 16'h0000);

        for (int i = 0; i < 64; i++)
            do_txn(24'h800000 + 24'(i), 1'b1, 16'($urandom), 0, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            ra  = 24'($urandom);
            rw  = 1'($urandom);
            rd  = 16'($urandom);
            rr  = 16'($urandom);
            rsp = ($urandom_range(0, 9) == 0) ? 1 : 0;
            do_txn(ra, rw, rd, rsp, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
